// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game types and constants: doodler FSM encoding,
//                USB arrow keycodes, screen size and the arrow decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    RIGHT    = 2'd0,
    LEFT     = 2'd1,
    SHOOTING = 2'd2
  } doodler_state_t;

  localparam logic [7:0] KEY_UP    = 8'd82;
  localparam logic [7:0] KEY_LEFT  = 8'd80;
  localparam logic [7:0] KEY_RIGHT = 8'd79;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Direction carried by a single keycode; NONE means "look elsewhere".
  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } shot_dir_t;

  function automatic shot_dir_t arrow_dir(input logic [7:0] key);
    case (key)
      KEY_UP:    return DIR_UP;
      KEY_LEFT:  return DIR_LEFT;
      KEY_RIGHT: return DIR_RIGHT;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_slot_scheduler_if
//  Description : Bundle between the doodler FSM/position logic (master) and
//                the bullet scheduler (slave), including the bullet outputs
//                consumed by the color mapper and collision logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bullet_slot_scheduler_if #(
  parameter int N_SLOTS = 4
);
  import game_pkg::*;

  doodler_state_t            state;
  logic [7:0]                keycode;
  logic [7:0]                keycode_ext;
  logic [9:0]                doodler_x;
  logic [9:0]                doodler_y;
  logic [N_SLOTS-1:0]        bullet_valid;
  logic [10*N_SLOTS-1:0]     bullet_x;
  logic [10*N_SLOTS-1:0]     bullet_y;
  logic                      fire_accepted;
  logic                      fire_dropped;

  modport master (
    output state, keycode, keycode_ext, doodler_x, doodler_y,
    input  bullet_valid, bullet_x, bullet_y, fire_accepted, fire_dropped
  );

  modport slave (
    input  state, keycode, keycode_ext, doodler_x, doodler_y,
    output bullet_valid, bullet_x, bullet_y, fire_accepted, fire_dropped
  );

endinterface
`default_nettype wire

// File: rtl/bullet_slot_scheduler_slot.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_slot
//  Description : One projectile slot: position, horizontal step and live flag.
//                Loads on spawn, otherwise moves up once per frame and retires
//                when the next step would leave the play field.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot
  import game_pkg::*;
#(
  parameter int SPEED = 8,
  parameter int X_MAX = 639
) (
  input  wire logic               frame_clk,
  input  wire logic               Reset,
  input  wire logic               spawn,
  input  wire logic [9:0]         spawn_x,
  input  wire logic [9:0]         spawn_y,
  input  wire logic signed [10:0] spawn_dx,
  output logic                    valid,
  output logic [9:0]              x,
  output logic [9:0]              y
);

  logic               r_valid;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic signed [10:0] r_dx;

  logic signed [10:0] w_x_next;
  logic               w_retire;

  // Next horizontal position in signed 11 bits; any overflow lands negative
  // and is therefore treated as off-field as well.
  always_comb begin
    w_x_next = $signed({1'b0, r_x}) + r_dx;
    w_retire = (r_y < 10'(SPEED)) || w_x_next[10] || (w_x_next > $signed(11'(X_MAX)));
  end

  // Spawn load has priority; a live slot either steps or retires each frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_dx    <= '0;
    end else if (spawn) begin
      r_valid <= 1'b1;
      r_x     <= spawn_x;
      r_y     <= spawn_y;
      r_dx    <= spawn_dx;
    end else if (r_valid) begin
      if (w_retire) begin
        r_valid <= 1'b0;
      end else begin
        r_x <= w_x_next[9:0];
        r_y <= r_y - 10'(SPEED);
      end
    end
  end

  assign valid = r_valid;
  assign x     = r_x;
  assign y     = r_y;

endmodule
`default_nettype wire

// File: rtl/bullet_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_slot_scheduler
//  Description : Projectile pool for the doodler. Detects entry into SHOOTING,
//                decodes the shot direction from the arrow keys, allocates the
//                lowest free slot subject to a cooldown and reports the outcome
//                with one-frame pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot_scheduler
  import game_pkg::*;
#(
  parameter int N_SLOTS   = 4,
  parameter int SPEED     = 8,
  parameter int DX_DIAG   = 4,
  parameter int SPAWN_OFS = 16,
  parameter int X_MAX     = 639,
  parameter int COOLDOWN  = 6
) (
  input  wire logic              frame_clk,
  input  wire logic              Reset,
  bullet_slot_scheduler_if.slave bus
);

  localparam int CD_W   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int SLOT_W = (N_SLOTS < 2) ? 1 : $clog2(N_SLOTS);

  doodler_state_t        r_prev_state;
  logic [CD_W-1:0]       r_cooldown;
  logic                  r_fire_accepted;
  logic                  r_fire_dropped;

  logic                  w_event;
  shot_dir_t             w_dir;
  logic signed [10:0]    w_dx;
  logic                  w_free_found;
  logic [SLOT_W-1:0]     w_free_idx;
  logic                  w_cool_open;
  logic                  w_room_above;
  logic                  w_accept;
  logic [9:0]            w_spawn_y;
  logic [N_SLOTS-1:0]    w_spawn;
  logic [N_SLOTS-1:0]    w_slot_valid;
  logic [10*N_SLOTS-1:0] w_slot_x;
  logic [10*N_SLOTS-1:0] w_slot_y;

  // Primary keycode decides the direction; the secondary one only fills in
  // when the primary carries no arrow.
  always_comb begin
    w_dir = arrow_dir(bus.keycode);
    if (w_dir == DIR_NONE) begin
      w_dir = arrow_dir(bus.keycode_ext);
    end
    case (w_dir)
      DIR_LEFT:  w_dx = 11'(-DX_DIAG);
      DIR_RIGHT: w_dx = 11'(DX_DIAG);
      default:   w_dx = '0;
    endcase
  end

  // Lowest-index slot that is empty at the start of the frame; a slot that is
  // retiring on this edge still reads as live here.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!w_slot_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(i);
      end
    end
  end

  // Fire decision. The accept frame counts as the first of the COOLDOWN
  // frames, so the gate reopens once only the current frame's tick remains.
  always_comb begin
    w_event      = (r_prev_state != SHOOTING) && (bus.state == SHOOTING);
    w_cool_open  = (r_cooldown <= CD_W'(1));
    w_room_above = (bus.doodler_y >= 10'(SPAWN_OFS));
    w_accept     = w_event && w_cool_open && w_free_found && w_room_above;
    w_spawn_y    = bus.doodler_y - 10'(SPAWN_OFS);
    w_spawn      = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (w_accept && (w_free_idx == SLOT_W'(i))) begin
        w_spawn[i] = 1'b1;
      end
    end
  end

  // Edge-detect history, cooldown counter and registered outcome pulses.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_prev_state    <= RIGHT;
      r_cooldown      <= '0;
      r_fire_accepted <= 1'b0;
      r_fire_dropped  <= 1'b0;
    end else begin
      r_prev_state    <= bus.state;
      r_fire_accepted <= w_accept;
      r_fire_dropped  <= w_event && !w_accept;
      if (w_accept) begin
        r_cooldown <= CD_W'(COOLDOWN);
      end else if (r_cooldown != '0) begin
        r_cooldown <= r_cooldown - CD_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    bullet_slot #(
      .SPEED (SPEED),
      .X_MAX (X_MAX)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .spawn     (w_spawn[g]),
      .spawn_x   (bus.doodler_x),
      .spawn_y   (w_spawn_y),
      .spawn_dx  (w_dx),
      .valid     (w_slot_valid[g]),
      .x         (w_slot_x[10*g +: 10]),
      .y         (w_slot_y[10*g +: 10])
    );
  end

  assign bus.bullet_valid  = w_slot_valid;
  assign bus.bullet_x      = w_slot_x;
  assign bus.bullet_y      = w_slot_y;
  assign bus.fire_accepted = r_fire_accepted;
  assign bus.fire_dropped  = r_fire_dropped;

endmodule
`default_nettype wire
